multi_edge_detect: RTL and testbench

MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

---
 rtl/edge_pkg.sv | 28 ++
 rtl/edge_chan.sv | 105 ++++++++++
 rtl/multi_edge_detect.sv | 60 ++++++
 tb/tb_multi_edge_detect.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for multi_edge_detect: event-mode encodings, parameter
// legal ranges and the mode decode helpers used by every channel.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int FILT_LEN_MIN    = 2;
  localparam int FILT_LEN_MAX    = 255;
  localparam int CNT_W_MIN       = 1;
  localparam int CNT_W_MAX       = 16;

  function automatic logic rise_en(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic fall_en(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: synchroniser, optional debounce filter
// (EDGE_FILT_EN), edge pulses, sticky flag and saturating event counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
`ifdef EDGE_FILT_EN
  parameter int FILT_LEN    = 3,
`endif
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             rise,
  output logic             down,
  output logic             flag,
  output logic [CNT_W-1:0] evt_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   synced;
  logic                   lvl;
  logic                   lvl_d_p1;
  logic                   rise_p2;
  logic                   down_p2;
  logic                   evt;
  logic                   flag_p3;
  logic [CNT_W-1:0]       cnt_p3;

  // Stage p0: metastability chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '0;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_p0[SYNC_STAGES-1];

`ifdef EDGE_FILT_EN
  localparam int FCNT_W = $clog2(FILT_LEN + 1);

  logic              filt_p1;
  logic [FCNT_W-1:0] fcnt_p1;

  // Stage p1: debounce, level only follows after FILT_LEN consecutive disagreeing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_p1 <= 1'b0;
      fcnt_p1 <= '0;
    end else if (synced != filt_p1) begin
      if (fcnt_p1 == FCNT_W'(FILT_LEN - 1)) begin
        filt_p1 <= synced;
        fcnt_p1 <= '0;
      end else begin
        fcnt_p1 <= fcnt_p1 + 1'b1;
      end
    end else begin
      fcnt_p1 <= '0;
    end
  end

  assign lvl = filt_p1;
`else
  assign lvl = synced;
`endif

  // Stage p1/p2: previous level and registered edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d_p1 <= 1'b0;
      rise_p2  <= 1'b0;
      down_p2  <= 1'b0;
    end else begin
      lvl_d_p1 <= lvl;
      rise_p2  <= lvl & ~lvl_d_p1;
      down_p2  <= ~lvl & lvl_d_p1;
    end
  end

  assign evt = (rise_p2 & rise_en(mode)) | (down_p2 & fall_en(mode));

  // Stage p3: sticky flag and counter; an event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_p3 <= 1'b0;
      cnt_p3  <= '0;
    end else begin
      flag_p3 <= evt | (flag_p3 & ~clr);
      if (evt)      cnt_p3 <= clr ? CNT_W'(1) : sat_inc(cnt_p3);
      else if (clr) cnt_p3 <= '0;
    end
  end

  assign rise    = rise_p2;
  assign down    = down_p2;
  assign flag    = flag_p3;
  assign evt_cnt = cnt_p3;

endmodule

// File: rtl/multi_edge_detect.sv
// N_CH independent edge detectors with per-channel event flags/counters and
// a shared interrupt. Optional debounce filter enabled by macro EDGE_FILT_EN.
module multi_edge_detect
  import edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       din,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       down,
  output logic [N_CH-1:0]       flag,
  output logic [N_CH*CNT_W-1:0] evt_cnt,
  output logic                  irq
);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
    $error("multi_edge_detect: N_CH out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("multi_edge_detect: SYNC_STAGES out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("multi_edge_detect: CNT_W out of range");
  end
`ifdef EDGE_FILT_EN
  if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
    $error("multi_edge_detect: FILT_LEN out of range");
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
`ifdef EDGE_FILT_EN
      .FILT_LEN    (FILT_LEN),
`endif
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din[i]),
      .mode    (mode[2*i +: 2]),
      .clr     (clr[i]),
      .rise    (rise[i]),
      .down    (down[i]),
      .flag    (flag[i]),
      .evt_cnt (evt_cnt[CNT_W*i +: CNT_W])
    );
  end

  assign irq = |flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: directed scenarios plus random traffic checked
// every cycle against a history-based reference model.
module tb_multi_edge_detect;

  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 3;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;
`ifdef EDGE_FILT_EN
  localparam int LAT = SYNC_STAGES + 1 + FILT_LEN;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       din;
  logic [2*N_CH-1:0]     mode;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       down;
  logic [N_CH-1:0]       flag;
  logic [N_CH*CNT_W-1:0] evt_cnt;
  logic                  irq;

  multi_edge_detect #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .rise(rise), .down(down), .flag(flag), .evt_cnt(evt_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: din history per edge since reset, derived level history,
  // expected pulses, flags and counts.
  bit dq[N_CH][$];
  bit lq[N_CH][$];
  int k;
  bit m_filt[N_CH];
  int m_run[N_CH];
  bit m_rise[N_CH];
  bit m_down[N_CH];
  bit m_flag[N_CH];
  int m_cnt[N_CH];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit din_at(int ch, int j);
    return (j < 1) ? 1'b0 : dq[ch][j-1];
  endfunction

  function automatic bit lvl_at(int ch, int j);
    return (j < 1) ? 1'b0 : lq[ch][j-1];
  endfunction

  task automatic model_reset();
    k = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      dq[ch].delete();
      lq[ch].delete();
      m_filt[ch] = 1'b0;
      m_run[ch]  = 0;
      m_rise[ch] = 1'b0;
      m_down[ch] = 1'b0;
      m_flag[ch] = 1'b0;
      m_cnt[ch]  = 0;
    end
  endtask

  task automatic model_step();
    k++;
    for (int ch = 0; ch < N_CH; ch++) begin
      bit lv;
      bit ev;
      dq[ch].push_back(din[ch]);
`ifdef EDGE_FILT_EN
      if (din_at(ch, k - SYNC_STAGES) != m_filt[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == FILT_LEN) begin
          m_filt[ch] = ~m_filt[ch];
          m_run[ch]  = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
      lv = m_filt[ch];
`else
      lv = din_at(ch, k - SYNC_STAGES + 1);
`endif
      lq[ch].push_back(lv);
      ev = (m_rise[ch] && mode[2*ch]) || (m_down[ch] && mode[2*ch+1]);
      if (ev)           m_cnt[ch] = clr[ch] ? 1 : ((m_cnt[ch] + 1 > CMAX) ? CMAX : m_cnt[ch] + 1);
      else if (clr[ch]) m_cnt[ch] = 0;
      m_flag[ch] = ev || (m_flag[ch] && !clr[ch]);
      m_rise[ch] = lvl_at(ch, k - 1) && !lvl_at(ch, k - 2);
      m_down[ch] = !lvl_at(ch, k - 1) && lvl_at(ch, k - 2);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [N_CH-1:0]       er, ed, ef;
    logic [N_CH*CNT_W-1:0] ec;
    for (int ch = 0; ch < N_CH; ch++) begin
      er[ch] = m_rise[ch];
      ed[ch] = m_down[ch];
      ef[ch] = m_flag[ch];
      ec[CNT_W*ch +: CNT_W] = CNT_W'(m_cnt[ch]);
    end
    chk("rise", 64'(rise), 64'(er));
    chk("down", 64'(down), 64'(ed));
    chk("flag", 64'(flag), 64'(ef));
    chk("evt_cnt", 64'(evt_cnt), 64'(ec));
    chk("irq", 64'(irq), 64'(|ef));
    chk("rise_down_excl", 64'(rise & down), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cnt_r, cnt_d, w;

    // Reset with din high through release
    rst_n = 1'b0;
    din   = '1;
    mode  = '1;
    clr   = '0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cnt_r = 0;
    repeat (LAT + 5) begin
      tick();
      cnt_r += int'(rise[0]);
    end
    chk("release_one_rise", 64'(cnt_r), 64'd1);

    // Quiesce and clear everything
    din = '0;
    repeat (LAT + 3) tick();
    clr = '1;
    tick();
    clr = '0;
    tick();
    chk("irq_cleared", 64'(irq), 64'd0);

    // ch0 rising edge, rising-only mode
    mode = 8'b11_11_11_01;
    din[0] = 1'b1;
    repeat (LAT - 1) tick();
    chk("ch0_before", 64'(rise[0]), 64'd0);
    tick();
    chk("ch0_rise", 64'(rise[0]), 64'd1);
    tick();
    chk("ch0_single", 64'(rise[0]), 64'd0);
    tick();
    chk("ch0_flag", 64'(flag[0]), 64'd1);
    chk("ch0_cnt", 64'(evt_cnt[0 +: CNT_W]), 64'd1);
    chk("ch0_irq", 64'(irq), 64'd1);

    // ch1 pulse, falling-only mode
    mode = 8'b11_11_10_01;
    cnt_r = 0;
    cnt_d = 0;
    din[1] = 1'b1;
    repeat (10) begin tick(); cnt_r += int'(rise[1]); cnt_d += int'(down[1]); end
    din[1] = 1'b0;
    repeat (10 + LAT) begin tick(); cnt_r += int'(rise[1]); cnt_d += int'(down[1]); end
    chk("ch1_rises", 64'(cnt_r), 64'd1);
    chk("ch1_downs", 64'(cnt_d), 64'd1);
    chk("ch1_cnt", 64'(evt_cnt[CNT_W +: CNT_W]), 64'd1);

    // ch2 saturation
    mode = '1;
    repeat (300) begin
      din[2] = 1'b1;
      repeat (4) tick();
      din[2] = 1'b0;
      repeat (4) tick();
    end
    repeat (LAT + 2) tick();
    chk("ch2_saturate", 64'(evt_cnt[2*CNT_W +: CNT_W]), 64'(CMAX));

    // ch3 clear coinciding with an enabled event
    din[3] = 1'b1;
    w = 0;
    while (!m_rise[3] && w < 40) begin tick(); w++; end
    chk("ch3_rise_seen", 64'(rise[3]), 64'd1);
    clr[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    chk("ch3_flag", 64'(flag[3]), 64'd1);
    chk("ch3_cnt", 64'(evt_cnt[3*CNT_W +: CNT_W]), 64'd1);
    din = '0;
    repeat (LAT + 3) tick();

`ifdef EDGE_FILT_EN
    // Debounce: short pulse rejected, longer pulse accepted
    cnt_r = 0;
    din[0] = 1'b1;
    repeat (2) begin tick(); cnt_r += int'(rise[0]); end
    din[0] = 1'b0;
    repeat (20) begin tick(); cnt_r += int'(rise[0]); end
    chk("filt_short_rejected", 64'(cnt_r), 64'd0);
    din[0] = 1'b1;
    repeat (5) tick();
    chk("filt_long_before", 64'(rise[0]), 64'd0);
    din[0] = 1'b0;
    tick();
    chk("filt_long_rise", 64'(rise[0]), 64'd1);
    repeat (15) tick();
`endif

    // Random traffic
    repeat (400) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 3) == 0) din[ch] = ~din[ch];
        clr[ch] = ($urandom_range(0, 7) == 0);
      end
      mode = 8'($urandom);
      tick();
    end
    clr = '0;

    // Reset in the middle of a pending transition
    din = '0;
    repeat (LAT + 3) tick();
    din = '1;
    repeat (2) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    din = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cnt_r = 0;
    repeat (LAT + 6) begin tick(); cnt_r += int'(|rise) + int'(|down); end
    chk("no_pulse_after_reset", 64'(cnt_r), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
